output_tile_buffer: RTL and testbench

- Sits directly downstream of the reshuffle permutation stage, between the PosT array output path and the output feature-map writer.
- Accepts one reshuffled N×N patch per valid/ready handshake and stores patches in a DEPTH-entry patch FIFO.
- Drains the FIFO one quantized row (N elements) per handshake.
- Generates the row-rotation `step` that drives the upstream permutation for the patch currently being presented.

---
 rtl/tile_buf_pkg.sv | 46 ++++
 rtl/output_tile_buffer_row_quantizer.sv | 31 +++
 rtl/output_tile_buffer.sv | 131 +++++++++++++
 tb/tb_output_tile_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_buf_pkg.sv
// Shared types, default sizing and the rounding/saturation helper for the
// output tile buffer.
package tile_buf_pkg;

    localparam int P_N         = 4;
    localparam int P_WIDTH     = 32;
    localparam int P_OUT_WIDTH = 16;
    localparam int P_SHIFT     = 8;
    localparam int P_DEPTH     = 4;

    localparam int PTR_W = $clog2(P_DEPTH);
    localparam int ROW_W = $clog2(P_N);

    typedef logic signed [P_N-1:0][P_N-1:0][P_WIDTH-1:0] patch_t;
    typedef logic signed [P_N-1:0][P_OUT_WIDTH-1:0]      row_t;

    // Round-half-up arithmetic shift followed by a clamp to a signed
    // out_width range. Working in 64 bits keeps the rounding add from
    // overflowing for any element width up to 63 bits.
    function automatic logic signed [63:0] sat_round(
        input  logic signed [63:0] x,
        input  int                 shift,
        input  int                 out_width,
        output logic               sat
    );
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y = x;
        if (shift > 0) begin
            y = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        sat = 1'b0;
        if (y > hi) begin
            y   = hi;
            sat = 1'b1;
        end else if (y < lo) begin
            y   = lo;
            sat = 1'b1;
        end
        return y;
    endfunction

endpackage

// File: rtl/output_tile_buffer_row_quantizer.sv
// Combinational quantizer for one patch row: N lanes of round/shift/clamp
// plus a count of how many lanes were clamped.
module row_quantizer
    import tile_buf_pkg::*;
#(
    parameter int N         = P_N,
    parameter int WIDTH     = P_WIDTH,
    parameter int OUT_WIDTH = P_OUT_WIDTH,
    parameter int SHIFT     = P_SHIFT
) (
    input  logic [N-1:0][WIDTH-1:0]     i_row,
    output logic [N-1:0][OUT_WIDTH-1:0] o_row,
    output logic [$clog2(N):0]          o_sat_cnt
);

    localparam int CNT_W = $clog2(N) + 1;

    logic [N-1:0] w_sat;

    // Quantize every lane and tally the clamp flags.
    always_comb begin
        o_row     = '0;
        w_sat     = '0;
        o_sat_cnt = '0;
        for (int i = 0; i < N; i++) begin
            o_row[i] = OUT_WIDTH'(sat_round(64'(signed'(i_row[i])), SHIFT, OUT_WIDTH, w_sat[i]));
            o_sat_cnt = o_sat_cnt + CNT_W'(w_sat[i]);
        end
    end

endmodule

// File: rtl/output_tile_buffer.sv
// Patch FIFO between the reshuffle stage and the feature-map writer.
// Whole patches go in, quantized rows come out; the push count also
// drives the row-rotation step fed back to the upstream permutation.
module output_tile_buffer
    import tile_buf_pkg::*;
#(
    parameter int N         = P_N,
    parameter int WIDTH     = P_WIDTH,
    parameter int OUT_WIDTH = P_OUT_WIDTH,
    parameter int SHIFT     = P_SHIFT,
    parameter int DEPTH     = P_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [N-1:0][N-1:0][WIDTH-1:0] in_patch,
    output logic [$clog2(N)-1:0]                step,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [N-1:0][OUT_WIDTH-1:0]  out_row,
    output logic [$clog2(N)-1:0]                out_row_idx,
    output logic                                out_last,
    output logic [$clog2(DEPTH):0]              occupancy,
    output logic [15:0]                         sat_count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int ROW_BITS = $clog2(N);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(N - 1);
    localparam logic [PTR_BITS:0]   OCC_FULL = (PTR_BITS + 1)'(DEPTH);

    logic [N-1:0][N-1:0][WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0]            r_wr_ptr;
    logic [PTR_BITS-1:0]            r_rd_ptr;
    logic [ROW_BITS-1:0]            r_row_idx;
    logic [ROW_BITS-1:0]            r_step;
    logic [PTR_BITS:0]              r_occ;
    logic [15:0]                    r_sat_count;

    logic                           w_push;
    logic                           w_pop;
    logic                           w_pop_last;
    logic [N-1:0][OUT_WIDTH-1:0]    w_q_row;
    logic [ROW_BITS:0]              w_row_sat;
    logic [16:0]                    w_sat_sum;

    // Handshake qualification; in_ready deliberately ignores out_ready so a
    // slot freed this cycle only becomes writable on the next one.
    assign in_ready   = (r_occ != OCC_FULL);
    assign out_valid  = (r_occ != '0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_pop_last = w_pop && (r_row_idx == ROW_LAST);
    assign w_sat_sum  = {1'b0, r_sat_count} + 17'(w_row_sat);

    row_quantizer #(
        .N         (N),
        .WIDTH     (WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_row_quantizer (
        .i_row     (r_mem[r_rd_ptr][r_row_idx]),
        .o_row     (w_q_row),
        .o_sat_cnt (w_row_sat)
    );

    // Row data is forced to zero while empty so stale slots never leak out.
    assign out_row     = out_valid ? w_q_row : '0;
    assign out_row_idx = r_row_idx;
    assign out_last    = out_valid && (r_row_idx == ROW_LAST);
    assign occupancy   = r_occ;
    assign step        = r_step;
    assign sat_count   = r_sat_count;

    // Patch storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_patch;
        end
    end

    // Write pointer and rotation step both advance once per accepted patch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_step   <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            r_step   <= r_step + ROW_BITS'(1);
        end
    end

    // Row walk within the head patch; the head is released after its last row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_idx <= '0;
            r_rd_ptr  <= '0;
        end else if (w_pop) begin
            if (r_row_idx == ROW_LAST) begin
                r_row_idx <= '0;
                r_rd_ptr  <= r_rd_ptr + PTR_BITS'(1);
            end else begin
                r_row_idx <= r_row_idx + ROW_BITS'(1);
            end
        end
    end

    // Patch count: push and head release in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({w_push, w_pop_last})
                2'b10:   r_occ <= r_occ + (PTR_BITS + 1)'(1);
                2'b01:   r_occ <= r_occ - (PTR_BITS + 1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Running count of clamped elements actually delivered, sticking at max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (w_pop) begin
            r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
        end
    end

endmodule

// File: tb/tb_output_tile_buffer.sv
// Testbench for output_tile_buffer: directed table vectors, tagged patch
// sequences for the FIFO corner cases, then a random stall run against a
// queue-based reference model.
module tb_output_tile_buffer;
    import tile_buf_pkg::*;

    localparam int N         = 4;
    localparam int WIDTH     = 32;
    localparam int OUT_WIDTH = 16;
    localparam int SHIFT     = 8;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    patch_t      in_patch;
    logic [1:0]  step;
    logic        out_valid;
    logic        out_ready;
    row_t        out_row;
    logic [1:0]  out_row_idx;
    logic        out_last;
    logic [2:0]  occupancy;
    logic [15:0] sat_count;

    int checks = 0;
    int errors = 0;

    output_tile_buffer #(
        .N(N), .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_patch    (in_patch),
        .step        (step),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .occupancy   (occupancy),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [15:0] y;
        int          s;
    } qvec_t;

    qvec_t qtab [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic patch_t tagged_patch(input int tag);
        patch_t p;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                p[r][c] = 32'((tag * 16 + r * 4 + c) * 256);
        return p;
    endfunction

    function automatic row_t tagged_row(input int tag, input int r);
        row_t e;
        for (int c = 0; c < N; c++) e[c] = 16'(tag * 16 + r * 4 + c);
        return e;
    endfunction

    // Reference quantizer: floor((x + 2^(S-1)) / 2^S), then clamp.
    function automatic longint q_model(input longint x, output int s);
        longint d, v, q;
        d = longint'(1) << SHIFT;
        v = x + d / 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        s = 0;
        if (q > 32767) begin q = 32767; s = 1; end
        if (q < -32768) begin q = -32768; s = 1; end
        return q;
    endfunction

    function automatic row_t model_row(input patch_t p, input int r, output int nsat);
        row_t e;
        int   s;
        nsat = 0;
        for (int c = 0; c < N; c++) begin
            e[c] = 16'(q_model(longint'(signed'(p[r][c])), s));
            nsat += s;
        end
        return e;
    endfunction

    function automatic patch_t rand_patch();
        patch_t p;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 3) == 0) p[r][c] = 32'($urandom);
                else p[r][c] = 32'(int'($urandom_range(0, 1 << 24)) - (1 << 23));
        return p;
    endfunction

    task automatic push_patch(input patch_t p);
        in_valid = 1'b1;
        in_patch = p;
        #1;
        chk("push_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Pop the four rows of the head patch checking tagged data; optionally
    // offer another patch in the cycle of the final-row pop.
    task automatic pop_patch(input int tag, input bit push_on_last, input int push_tag);
        for (int r = 0; r < N; r++) begin
            out_ready = 1'b1;
            if (r == N - 1 && push_on_last) begin
                in_valid = 1'b1;
                in_patch = tagged_patch(push_tag);
            end
            #1;
            chk($sformatf("pop_valid_t%0d_r%0d", tag, r), out_valid, 1);
            chk($sformatf("pop_row_t%0d_r%0d", tag, r), out_row, tagged_row(tag, r));
            chk($sformatf("pop_idx_t%0d_r%0d", tag, r), out_row_idx, r);
            chk($sformatf("pop_last_t%0d_r%0d", tag, r), out_last, (r == N - 1));
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    patch_t mq [$];
    int     m_row, m_push, m_sat, nsat, cum_sat;
    bit     m_do_push, m_do_pop;
    patch_t p_tmp, pushed;
    row_t   e_row;

    initial begin
        qtab[0]  = '{32'd383,          16'd1,       0};
        qtab[1]  = '{32'd384,          16'd2,       0};
        qtab[2]  = '{-32'sd385,        -16'sd2,     0};
        qtab[3]  = '{32'd0,            16'd0,       0};
        qtab[4]  = '{32'h7FFF_FFFF,    16'h7FFF,    1};
        qtab[5]  = '{32'h8000_0000,    16'h8000,    1};
        qtab[6]  = '{32'd127,          16'd0,       0};
        qtab[7]  = '{32'd128,          16'd1,       0};
        qtab[8]  = '{-32'sd128,        16'd0,       0};
        qtab[9]  = '{-32'sd129,        -16'sd1,     0};
        qtab[10] = '{32'd8388479,      16'h7FFF,    0};
        qtab[11] = '{32'd8388480,      16'h7FFF,    1};
        qtab[12] = '{-32'sd8388608,    16'h8000,    0};
        qtab[13] = '{-32'sd8388737,    16'h8000,    1};
        qtab[14] = '{32'd256,          16'd1,       0};
        qtab[15] = '{-32'sd256,        -16'sd1,     0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_patch  = '0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_step", step, 0);
        chk("rst_sat", sat_count, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single patch, exact values.
        push_patch(tagged_patch(0));
        chk("single_step", step, 1);
        chk("single_occ", occupancy, 1);
        chk("single_valid", out_valid, 1);
        pop_patch(0, 1'b0, 0);
        chk("single_drained_valid", out_valid, 0);
        chk("single_drained_occ", occupancy, 0);

        // Rounding / saturation table.
        for (int i = 0; i < 16; i++) p_tmp[i / 4][i % 4] = qtab[i].x;
        push_patch(p_tmp);
        cum_sat = 0;
        for (int r = 0; r < N; r++) begin
            out_ready = 1'b1;
            #1;
            for (int c = 0; c < N; c++)
                chk($sformatf("quant_r%0d_c%0d", r, c), out_row[c], qtab[r * 4 + c].y);
            for (int c = 0; c < N; c++) cum_sat += qtab[r * 4 + c].s;
            tick();
            out_ready = 1'b0;
            chk($sformatf("quant_sat_r%0d", r), sat_count, cum_sat);
        end

        // Fill to full with the output stalled.
        for (int t = 0; t < 4; t++) push_patch(tagged_patch(t));
        chk("full_occ", occupancy, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_patch = tagged_patch(9);
        tick();
        in_valid = 1'b0;
        chk("full_reject_occ", occupancy, 4);
        // A push offered with the final-row pop of a full FIFO is refused.
        pop_patch(0, 1'b1, 99);
        chk("full_after_pop_occ", occupancy, 3);
        chk("full_after_pop_ready", in_ready, 1);
        push_patch(tagged_patch(4));
        chk("refill_occ", occupancy, 4);
        chk("refill_step", step, 3);

        // Drain through the pointer wrap, with concurrent push/pop at occ=2.
        pop_patch(1, 1'b0, 0);
        pop_patch(2, 1'b0, 0);
        chk("conc_pre_occ", occupancy, 2);
        pop_patch(3, 1'b1, 5);
        chk("conc_occ_a", occupancy, 2);
        pop_patch(4, 1'b1, 6);
        chk("conc_occ_b", occupancy, 2);
        pop_patch(5, 1'b1, 7);
        chk("conc_occ_c", occupancy, 2);
        pop_patch(6, 1'b0, 0);
        pop_patch(7, 1'b0, 0);
        chk("wrap_empty_valid", out_valid, 0);
        chk("wrap_step", step, 2);

        // Asynchronous reset with two patches stored.
        push_patch(tagged_patch(1));
        push_patch(tagged_patch(2));
        chk("prerst_occ", occupancy, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_step", step, 0);
        chk("arst_sat", sat_count, 0);
        chk("arst_row", out_row, 0);
        chk("arst_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // Random stall run against the queue model.
        m_row  = 0;
        m_push = 0;
        m_sat  = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_patch  = rand_patch();
            #1;
            nsat = 0;
            chk("rnd_occ", occupancy, mq.size());
            chk("rnd_in_ready", in_ready, (mq.size() < DEPTH));
            chk("rnd_out_valid", out_valid, (mq.size() != 0));
            chk("rnd_step", step, m_push % 4);
            chk("rnd_sat", sat_count, m_sat);
            if (mq.size() != 0) begin
                e_row = model_row(mq[0], m_row, nsat);
                chk("rnd_row", out_row, e_row);
                chk("rnd_idx", out_row_idx, m_row);
                chk("rnd_last", out_last, (m_row == N - 1));
            end
            m_do_push = in_valid && (mq.size() < DEPTH);
            m_do_pop  = out_ready && (mq.size() != 0);
            pushed    = in_patch;
            tick();
            if (m_do_pop) begin
                m_sat = (m_sat + nsat > 65535) ? 65535 : m_sat + nsat;
                if (m_row == N - 1) begin
                    void'(mq.pop_front());
                    m_row = 0;
                end else begin
                    m_row++;
                end
            end
            if (m_do_push) begin
                mq.push_back(pushed);
                m_push++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
